// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the single-port memory arbiter.
// Included by the arbiter top and by the bench.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive cycles in which a pending fetch was refused.
// at_lim tells the arbiter that fetch must win this cycle.
module arb_starve_cnt #(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic req,
    input  logic gnt,
    output logic at_lim
);

    logic [3:0] wait_cnt;

    // Saturates at the limit and holds there until fetch is served or withdraws.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wait_cnt <= '0;
        end else if (!req || gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 4'(STARVE_LIM)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign at_lim = (wait_cnt == 4'(STARVE_LIM));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Data has priority; a starvation counter guarantees fetch progress.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_LIM = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic   if_win;
    logic   d_win;
    logic   fetch_at_lim;
    owner_t rd_owner;

    arb_starve_cnt #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve (
        .clk    (clk),
        .clr    (clr),
        .req    (if_req),
        .gnt    (if_win),
        .at_lim (fetch_at_lim)
    );

    // Gating on clr keeps grants off for the whole time reset is asserted.
    always_comb begin
        if_win = 1'b0;
        d_win  = 1'b0;
        if (clr) begin
            if (fetch_at_lim && if_req) begin
                if_win = 1'b1;
            end else if (d_req) begin
                d_win = 1'b1;
            end else if (if_req) begin
                if_win = 1'b1;
            end
        end
    end

    assign if_gnt   = if_win;
    assign d_gnt    = d_win;
    assign mem_en   = if_win | d_win;
    assign mem_wen  = d_win & d_we;
    assign mem_addr = d_win ? d_addr : (if_win ? if_addr : '0);
    assign mem_din  = d_win ? d_wdata : '0;

    // Remembers who owns the word coming back from memory next cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_owner <= OWN_NONE;
        end else if (if_win) begin
            rd_owner <= OWN_IF;
        end else if (d_win && !d_we) begin
            rd_owner <= OWN_D;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    assign if_rvalid = (rd_owner == OWN_IF);
    assign d_rvalid  = (rd_owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_dout : '0;
    assign d_rdata   = d_rvalid ? mem_dout : '0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            conflict_cnt <= '0;
        end else if (if_req && d_req && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural synchronous memory.
// Expected read returns are queued at stimulus time and popped one cycle later.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int LIM = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic [CW-1:0] conflict_cnt;

    typedef struct packed {
        owner_t        owner;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    int            checks = 0;
    int            fails  = 0;

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_LIM (LIM),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return (a == 8'h04) ? 32'h8C22_0000 : {16'hC0DE, a, ~a};
    endfunction

    // Synchronous memory; reloads its preset contents while reset is held.
    always @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
            mem_dout <= '0;
        end else if (mem_en) begin
            if (mem_wen) mem[mem_addr] <= mem_din;
            mem_dout <= mem[mem_addr];
        end
    end

    function automatic logic [2*DW+1:0] exp_ret(input exp_t e);
        return {e.owner == OWN_IF, (e.owner == OWN_IF) ? e.data : 32'h0,
                e.owner == OWN_D,  (e.owner == OWN_D)  ? e.data : 32'h0};
    endfunction

    task automatic push_exp(input owner_t o, input logic [AW-1:0] a);
        exp_t e;
        e.owner = o;
        e.data  = (o == OWN_NONE) ? 32'h0 : ref_mem[a];
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clr = 1'b0;
        idle_inputs();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [2*DW+AW+DW+CW+5:0] outs;
        apply_reset();
        #1;
        outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                mem_en, mem_wen, mem_addr, mem_din, conflict_cnt};
        checks++;
        if (outs !== '0) begin
            fails++; $display("[TB] FAIL reset_outputs: got %h, want 0", outs);
        end
        if_req = 1'b1; if_addr = 8'h10;
        #1;
        checks++;
        if ({if_gnt, mem_addr} !== {1'b1, 8'h10}) begin
            fails++; $display("[TB] FAIL reset_pre_grant: got gnt=%b addr=%h, want 1/10", if_gnt, mem_addr);
        end
        clr = 1'b0;
        #1;
        outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                mem_en, mem_wen, mem_addr, mem_din, conflict_cnt};
        checks++;
        if (outs !== '0) begin
            fails++; $display("[TB] FAIL reset_async_clear: got %h, want 0", outs);
        end
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h11;
        next_cycle();
        checks++;
        if ({d_gnt, if_rvalid, mem_en} !== 3'b000) begin
            fails++; $display("[TB] FAIL reset_gated: got gnt=%b rvalid=%b en=%b, want 000", d_gnt, if_rvalid, mem_en);
        end
        clr = 1'b1;
        #1;
        checks++;
        if ({d_gnt, if_rvalid} !== 2'b10) begin
            fails++; $display("[TB] FAIL reset_release_grant: got d_gnt=%b if_rvalid=%b, want 1/0", d_gnt, if_rvalid);
        end
        push_exp(OWN_D, 8'h11);
        next_cycle();
        d_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({if_rvalid, if_rdata, d_rvalid, d_rdata} !== exp_ret(e) || conflict_cnt !== '0) begin
            fails++; $display("[TB] FAIL reset_first_load: got %b %h %b %h cnt=%0d, want %h cnt=0",
                              if_rvalid, if_rdata, d_rvalid, d_rdata, conflict_cnt, exp_ret(e));
        end
    endtask

    task automatic test_lone_fetch();
        exp_t e;
        if_req = 1'b1; if_addr = 8'h04;
        #1;
        checks++;
        if ({if_gnt, d_gnt, mem_en, mem_wen, mem_addr} !== {4'b1010, 8'h04}) begin
            fails++; $display("[TB] FAIL fetch_issue: got gnt=%b%b en=%b wen=%b addr=%h, want 10 1 0 04",
                              if_gnt, d_gnt, mem_en, mem_wen, mem_addr);
        end
        push_exp(OWN_IF, 8'h04);
        next_cycle();
        if_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({if_rvalid, if_rdata, d_rvalid, d_rdata} !== exp_ret(e)) begin
            fails++; $display("[TB] FAIL fetch_return: got %b %h %b %h, want %h",
                              if_rvalid, if_rdata, d_rvalid, d_rdata, exp_ret(e));
        end
    endtask

    task automatic test_store_load();
        exp_t e;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({d_gnt, if_gnt, mem_en, mem_wen, mem_addr, mem_din} !== {4'b1011, 8'h20, 32'hDEAD_BEEF}) begin
            fails++; $display("[TB] FAIL store_issue: got gnt=%b%b en=%b wen=%b addr=%h din=%h",
                              d_gnt, if_gnt, mem_en, mem_wen, mem_addr, mem_din);
        end
        ref_mem[8'h20] = 32'hDEAD_BEEF;
        push_exp(OWN_NONE, 8'h00);
        next_cycle();
        d_we = 1'b0; d_wdata = '0;
        e = exp_q.pop_front();
        checks++;
        if ({if_rvalid, if_rdata, d_rvalid, d_rdata} !== exp_ret(e)) begin
            fails++; $display("[TB] FAIL store_no_rvalid: got %b %h %b %h, want %h",
                              if_rvalid, if_rdata, d_rvalid, d_rdata, exp_ret(e));
        end
        #1;
        checks++;
        if ({d_gnt, mem_wen, mem_addr} !== {2'b10, 8'h20}) begin
            fails++; $display("[TB] FAIL load_issue: got gnt=%b wen=%b addr=%h, want 1 0 20", d_gnt, mem_wen, mem_addr);
        end
        push_exp(OWN_D, 8'h20);
        next_cycle();
        d_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({if_rvalid, if_rdata, d_rvalid, d_rdata} !== exp_ret(e)) begin
            fails++; $display("[TB] FAIL load_return: got %b %h %b %h, want %h",
                              if_rvalid, if_rdata, d_rvalid, d_rdata, exp_ret(e));
        end
    endtask

    task automatic test_contention();
        exp_t e;
        logic exp_if;
        apply_reset();
        if_req = 1'b1; if_addr = 8'h08;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
        // Fixed pattern under continuous contention: four data grants, then fetch.
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_if = ((i % 5) == 4);
            checks++;
            if ({if_gnt, d_gnt} !== {exp_if, ~exp_if}) begin
                fails++; $display("[TB] FAIL contention_gnt[%0d]: got if=%b d=%b, want if=%b d=%b",
                                  i, if_gnt, d_gnt, exp_if, ~exp_if);
            end
            push_exp(exp_if ? OWN_IF : OWN_D, exp_if ? 8'h08 : 8'h30);
            next_cycle();
            e = exp_q.pop_front();
            checks++;
            if ({if_rvalid, if_rdata, d_rvalid, d_rdata} !== exp_ret(e)) begin
                fails++; $display("[TB] FAIL contention_ret[%0d]: got %b %h %b %h, want %h",
                                  i, if_rvalid, if_rdata, d_rvalid, d_rdata, exp_ret(e));
            end
        end
        idle_inputs();
        checks++;
        if (conflict_cnt !== 4'd10) begin
            fails++; $display("[TB] FAIL contention_cnt: got %0d, want 10", conflict_cnt);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        if_req = 1'b1; if_addr = 8'h00;
        #1;
        checks++;
        if ({if_gnt, d_gnt, mem_addr} !== {2'b10, 8'h00}) begin
            fails++; $display("[TB] FAIL b2b_fetch_issue: got gnt=%b%b addr=%h", if_gnt, d_gnt, mem_addr);
        end
        push_exp(OWN_IF, 8'h00);
        next_cycle();
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h01;
        e = exp_q.pop_front();
        checks++;
        if ({if_rvalid, if_rdata, d_rvalid, d_rdata} !== exp_ret(e)) begin
            fails++; $display("[TB] FAIL b2b_fetch_ret: got %b %h %b %h, want %h",
                              if_rvalid, if_rdata, d_rvalid, d_rdata, exp_ret(e));
        end
        #1;
        checks++;
        if ({d_gnt, if_gnt, mem_addr} !== {2'b10, 8'h01}) begin
            fails++; $display("[TB] FAIL b2b_load_issue: got gnt=%b%b addr=%h", d_gnt, if_gnt, mem_addr);
        end
        push_exp(OWN_D, 8'h01);
        next_cycle();
        d_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({if_rvalid, if_rdata, d_rvalid, d_rdata} !== exp_ret(e)) begin
            fails++; $display("[TB] FAIL b2b_load_ret: got %b %h %b %h, want %h",
                              if_rvalid, if_rdata, d_rvalid, d_rdata, exp_ret(e));
        end
    endtask

    task automatic test_saturation();
        int want;
        apply_reset();
        if_req = 1'b1; if_addr = 8'h08;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            want = (i + 1 > 15) ? 15 : i + 1;
            checks++;
            if (conflict_cnt !== CW'(want)) begin
                fails++; $display("[TB] FAIL sat_cnt[%0d]: got %0d, want %0d", i, conflict_cnt, want);
            end
        end
        idle_inputs();
        next_cycle();
        checks++;
        if (conflict_cnt !== 4'd15) begin
            fails++; $display("[TB] FAIL sat_hold: got %0d, want 15", conflict_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        idle_inputs();
        clr = 1'b0;
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory_unit port between the instruction-fetch requester and the data load/store requester, so a single memory instance can replace the separate imu and dmu.
- Arbitrates every cycle and steers address, write data and write enable from the winner to the memory.
- Returns read data to the winner one cycle later.
- Data has priority. A starvation counter guarantees fetch progress, and a saturating counter records conflict cycles for performance debug.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 32, data width.
- STARVE_LIM, 4, consecutive denied fetch cycles after which fetch wins (range 1..15).
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- clr  in  1  asynchronous, active-low reset; clears all state immediately.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  d_rdata valid (loads only).
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory enable.
- mem_wen  out  1  memory write enable (active-high).
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data; valid the cycle after a read is issued.
- conflict_cnt  out  CNT_W  saturating count of cycles with if_req and d_req both high.

Behaviour:
- Reset (clr=0, async):
  - wait_cnt=0, rd_owner=NONE, conflict_cnt=0.
  - All outputs are 0: gnt, rvalid, mem_en, mem_wen, addr/data.
  - A read in flight is dropped, and no rvalid ever appears for it.
  - Grants are gated off while clr=0.
- Arbitration is combinational, each cycle:
  - If wait_cnt==STARVE_LIM and if_req: fetch wins.
  - Else if d_req: data wins.
  - Else if if_req: fetch wins.
  - Else: none.
- Exactly one gnt at most per cycle; the gnt pulse lasts one cycle. The requester must present its next request (or drop req) the following cycle.
- Memory steering:
  - mem_en = winner valid.
  - mem_addr and mem_din are taken from the winner.
  - mem_wen = d_we when data wins, 0 otherwise.
  - With no winner: mem_addr=0, mem_din=0.
- Read return:
  - rd_owner is registered at grant of a read (fetch, or data with d_we=0).
  - Next cycle, the matching rvalid=1 and rdata=mem_dout. The other requester's rdata is 0.
  - Latency is gnt in cycle N, rvalid in N+1. Fully pipelined: a new grant in N+1 is allowed while returning data from N.
- Stores produce no rvalid. A store is complete at d_gnt.
- wait_cnt:
  - Increments when if_req && !if_gnt, saturating at STARVE_LIM.
  - Clears on if_gnt or !if_req.
  - Under continuous contention this gives a pattern of 4 data grants then 1 fetch grant (STARVE_LIM=4).
- conflict_cnt: +1 each cycle with if_req && d_req; saturates at all-ones and never wraps.
- Address width: addresses pass unchanged; no bounds checking.
- Requests are sampled only while clr=1. A request held across reset release is arbitrated in the first cycle after release.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_IF, OWN_D}.
  - ADDR_W and DATA_W defaults.
- One sub-module, arb_starve_cnt: the saturating wait counter with inputs req, gnt, clk, clr and output at_lim.

Test Plan:
- Reset mid-read: issue fetch read at addr 0x10, assert clr=0 in the next cycle before the clock edge -> all outputs 0 immediately; no if_rvalid after release; wait_cnt and conflict_cnt read 0.
- Lone fetch: if_req=1, if_addr=0x04, mem holds 0x8C220000 -> if_gnt in cycle N, mem_addr=0x04, mem_wen=0; if_rvalid=1 with if_rdata=0x8C220000 in N+1.
- Store then load: d_req, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> d_gnt, mem_wen=1, no d_rvalid. Next cycle load from 0x20 -> d_rvalid in N+1 with d_rdata=0xDEADBEEF.
- Continuous contention for 10 cycles (STARVE_LIM=4) -> grant sequence D,D,D,D,IF,D,D,D,D,IF; conflict_cnt=10; never both gnt high.
- Back-to-back pipelining: fetch 0x00 in cycle N, data load 0x01 in N+1 -> if_rvalid in N+1, d_rvalid in N+2, each with the correct word; only the owner's rvalid is high.
- Saturation: CNT_W=4 with 20 contention cycles -> conflict_cnt holds 15 and never wraps.
